// File: rtl/magic_nor_sequencer.sv
// Two-phase (INIT/EXEC) sequencer that runs a stored program of NOR ops over
// an NCELLS-bit MAGIC crossbar row, one gate per op.
module magic_nor_sequencer #(
  parameter int NCELLS     = 32,
  parameter int NIN        = 8,
  parameter int PROG_DEPTH = 32,
  parameter int AW         = 5,
  parameter int PW         = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [3*AW-1:0]   prog_wdata,
  input  logic [PW:0]       prog_len,
  input  logic              start,
  input  logic [NIN-1:0]    in_vec,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PW:0]       op_count,
  output logic [NCELLS-1:0] cells
);

  localparam logic [AW:0] NIN_L    = (AW+1)'(NIN);
  localparam logic [AW:0] NCELLS_L = (AW+1)'(NCELLS);
  localparam logic [PW:0] DEPTH_L  = (PW+1)'(PROG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_EXEC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3*AW-1:0]     mem [PROG_DEPTH];
  logic [PW:0]         pc_q, len_q;
  logic [NCELLS-1:0]   cells_q;
  logic                err_q;
  logic [3*AW-1:0]     op;
  logic [AW-1:0]       dst, srca, srcb;
  logic                illegal, last_op, accept;

  // Output cell must be a non-input cell distinct from both operands,
  // otherwise INIT would destroy an operand before EXEC reads it.
  function automatic logic op_illegal(input logic [AW-1:0] d,
                                      input logic [AW-1:0] a,
                                      input logic [AW-1:0] b);
    op_illegal = ({1'b0, d} < NIN_L) || ({1'b0, d} >= NCELLS_L) ||
                 ({1'b0, a} >= NCELLS_L) || ({1'b0, b} >= NCELLS_L) ||
                 (d == a) || (d == b);
  endfunction

  assign op      = mem[pc_q[PW-1:0]];
  assign dst     = op[3*AW-1:2*AW];
  assign srcb    = op[2*AW-1:AW];
  assign srca    = op[AW-1:0];
  assign illegal = op_illegal(dst, srca, srcb);
  assign last_op = (pc_q == (len_q - (PW+1)'(1)));
  assign accept  = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (prog_len == '0 || prog_len > DEPTH_L) state_d = S_DONE;
        else                                      state_d = S_INIT;
      end
      S_INIT: state_d = illegal ? S_DONE : S_EXEC;
      S_EXEC: state_d = last_op ? S_DONE : S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_INIT) || (state_q == S_EXEC);
    done = (state_q == S_DONE);
  end

  // A write in the same edge as an accepted start lands before INIT reads it.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cells_q <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          cells_q <= {{(NCELLS-NIN){1'b1}}, in_vec};
          len_q   <= prog_len;
          pc_q    <= '0;
          err_q   <= (prog_len > DEPTH_L);
        end
        S_INIT: begin
          if (illegal) err_q <= 1'b1;
          else         cells_q[dst] <= 1'b1;
        end
        S_EXEC: begin
          cells_q[dst] <= ~(cells_q[srca] | cells_q[srcb]);
          pc_q         <= pc_q + (PW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign err      = err_q;
  assign op_count = pc_q;
  assign cells    = cells_q;

endmodule
